graph_lut_streamer: RTL

GRAPH_LUT_STREAMER -- requirements
Module: graph_lut_streamer

---
 rtl/graph_pkg.sv | 13 +
 rtl/graph_sync_fifo.sv | 46 ++++
 rtl/graph_lut_streamer.sv | 115 +++++++++++
 3 files changed

// File: rtl/graph_pkg.sv
// Shared types and defaults for the LUT streaming engine: FSM state encoding
// and the default depth of the output holding FIFO.
package graph_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/graph_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, only the
// pointers and count are.
module graph_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/graph_lut_streamer.sv
// Streams length bytes from a source SRAM through an external registered LUT
// into a destination port, with credit-based flow control into a small FIFO.
module graph_lut_streamer
  import graph_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        lut_addr,
  input  logic [7:0]        lut_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, issued, wr_count;
  logic              vld_p0, vld_p1;
  logic [1:0]        inflight;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic              pop;
  logic              credit_ok;

  // A read's byte is on rd_data one cycle after rd_en (vld_p0) and on
  // lut_data the cycle after that (vld_p1), where it is pushed.
  assign inflight  = {1'b0, vld_p0} + {1'b0, vld_p1};
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign pop       = wr_en && wr_ready;
  assign lut_addr  = rd_data;

  graph_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p1),
    .push_data (lut_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (length == '0) ? DONE : RUN;
      RUN:  if ((wr_count + LEN_W'(pop)) == len_q) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN) || (state == DONE);
    done  = (state == DONE);
    rd_en = (state == RUN) && (issued < len_q) && credit_ok;
  end

  // Job fields latch only in IDLE, so a start while busy changes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      issued   <= '0;
      wr_count <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      if (state == IDLE && start) begin
        src_q    <= src_base;
        dst_q    <= dst_base;
        len_q    <= length;
        issued   <= '0;
        wr_count <= '0;
      end else begin
        if (rd_en) issued   <= issued + 1'b1;
        if (pop)   wr_count <= wr_count + 1'b1;
      end
    end
  end

  assign rd_addr = src_q + ADDR_W'(issued);
  assign wr_addr = dst_q + ADDR_W'(wr_count);
  assign wr_en   = !fifo_empty;
  assign wr_data = fifo_empty ? 8'h00 : fifo_head;

endmodule
